proc_datapath: RTL
==================

# proc_datapath

Datapath for the 8-bit accumulator processor: the stage directly downstream of the instruction decoder, executing its control word every cycle. It holds the instruction register, program counter, accumulator and output-port register, plus the ALU and the operand/address multiplexers. It returns the raw `carry`/`zero` ALU flags, which the decoder latches, and the current IR to the decoder. It drives the single-port memory and the I/O ports.

## Interface
Parameters:
- `DW`, 8: data, accumulator and IR width.
- `AW`, 4: memory address and PC width; the operand is `ir[AW-1:0]`.

Ports:
- `clk` input, 1: sole clock, rising edge.
- `clr` input, 1: reset, synchronous, active-high.
- `alu` input, 5: ALU function code from the decoder.
- `muxa` input, 1: ALU A select; 0 = ACC, 1 = PC (zero-extended).
- `muxb` input, 1: ALU B select when `muxc`=0; 1 = `mem_rdata`, 0 = operand (zero-extended).
- `muxc` input, 1: I/O select; ALU B = `in_port` and writes target `out_port`.
- `rw` input, 1: write strobe.
- `en_ir` input, 1: load IR from `mem_rdata`; also selects address = PC.
- `en_da` input, 1: load ACC from ALU result.
- `en_pc` input, 1: load PC from ALU result `[AW-1:0]`.
- `ir` output, DW: instruction register.
- `carry` output, 1: ALU carry/borrow, combinational.
- `zero` output, 1: ALU result == 0, combinational.
- `mem_addr` output, AW: `en_ir` ? PC : operand.
- `mem_rdata` input, DW: memory read data, combinational (asynchronous read).
- `mem_wdata` output, DW: always ACC.
- `mem_we` output, 1: `rw & ~muxc`.
- `in_port` input, DW: external input.
- `out_port` output, DW: registered output value.
- `out_strobe` output, 1: one-cycle pulse after each `out_port` update.

## Operation
- ALU codes:
  - 00000 ADD: A+B.
  - 01100 SUB: A−B.
  - 00001 AND: A&B.
  - 00011 PASS_B: B.
  - 00010 PASS_A: A.
  - 10100 INC: A+1.
  - Any other code gives result 0, carry 0.
- Carry:
  - ADD/INC: bit DW of the (DW+1)-bit sum.
  - SUB: 1 when A<B unsigned (borrow).
  - AND/PASS: 0.
- Result is DW bits, modulo 2^DW. `zero` is evaluated on the DW-bit result.
- Register updates on the rising edge, when not in reset:
  - IR ← `mem_rdata` if `en_ir`.
  - ACC ← result if `en_da`.
  - PC ← result[AW-1:0] if `en_pc`.
  - `out_port` ← result if `rw & muxc`.
- `out_strobe` is registered: it is 1 on the cycle after a port write, otherwise 0.
- Simultaneous enables are legal. Each register samples the same combinational result, or `mem_rdata` for IR.
- Instruction mapping:
  - LOAD: `muxb`=1, PASS_B, `en_da` → ACC ← mem[operand].
  - INPUT: `muxc`=1, PASS_B → ACC ← `in_port`.
  - OUTPUT: PASS_A, `muxa`=0, `muxc`=1, `rw` → `out_port` ← ACC.
  - JUMP: `muxb`=0, PASS_B, `en_pc` → PC ← operand.
  - INC phase: `muxa`=1, INC, `en_pc` → PC ← PC+1, wrapping 2^AW−1 → 0.

## Timing
- Reset: `clr` high at an edge forces PC=0, IR=0, ACC=0, `out_port`=0, `out_strobe`=0. Reset takes priority over all enables, including mid-instruction.
- Combinational paths, with no register in between:
  - control inputs and `mem_rdata`/`in_port` → `carry`, `zero`, `mem_addr`, `mem_we`;
  - ACC → `mem_wdata`.
- Latency: one edge from enable to register update; `out_strobe` follows the `out_port` update by one cycle.
- `mem_we` is high in the same cycle as `rw`. Memory captures `mem_wdata` at that edge. The block holds no write state.
- Flags are not registered here; the decoder samples them.
- No handshakes and no stalls: the datapath obeys the control word unconditionally every cycle.

## Structure
- Shared package `proc_pkg`:
  - ALU code constants (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_PASS_A`, `ALU_PASS_B`, `ALU_INC`);
  - default `DW`/`AW`.
- The decoder is to import the same package.
- Sub-module `proc_alu`: combinational; inputs A, B and the code; outputs result, carry, zero.
- `proc_datapath` holds the muxes and the five registers.

## Test plan
- Reset: `clr`=1 for 2 cycles with all enables high and `mem_rdata`=8'hFF → PC, IR, ACC, `out_port` = 0 and `out_strobe`=0.
- Fetch/INC:
  - `en_ir`=1 with PC=3 → `mem_addr`=3; IR captures `mem_rdata`=8'h47.
  - INC with `en_pc` from PC=15 → PC=0, `carry`=0.
- ADD with carry: ACC=8'hF0, `muxb`=1, `mem_rdata`=8'h20, ADD, `en_da` → ACC=8'h10, `carry`=1, `zero`=0.
  - 8'h01 + 8'hFF → ACC=0, `zero`=1, `carry`=1.
- SUB borrow: ACC=8'h05, B=8'h07 → ACC=8'hFE, `carry`=1.
  - 8'h07 − 8'h07 → 0, `zero`=1, `carry`=0.
- I/O:
  - `in_port`=8'hA5, INPUT word → ACC=8'hA5.
  - Then OUTPUT word → `out_port`=8'hA5, `out_strobe` high exactly one cycle later, `mem_we`=0.
- Memory write and jump:
  - `rw`=1, `muxc`=0, operand=9 → `mem_we`=1, `mem_addr`=9, `mem_wdata`=ACC.
  - JUMP operand 12 → PC=12.
  - Mid-sequence `clr` zeroes all state at the next edge.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit accumulator processor: ALU function codes and default widths.
// Imported by the datapath, its ALU and the instruction decoder.
package proc_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 4;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_ADD    = 5'b00000;
    localparam alu_op_t ALU_AND    = 5'b00001;
    localparam alu_op_t ALU_PASS_A = 5'b00010;
    localparam alu_op_t ALU_PASS_B = 5'b00011;
    localparam alu_op_t ALU_SUB    = 5'b01100;
    localparam alu_op_t ALU_INC    = 5'b10100;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: result, carry/borrow and zero flag for the accumulator processor.
// Unknown function codes produce a zero result with no carry.
module proc_alu
    import proc_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       op,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            ALU_SUB: begin
                // The extra top bit of the difference is the unsigned borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            ALU_INC: begin
                wide   = {1'b0, a} + {{DW{1'b0}}, 1'b1};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            ALU_AND:    result = a & b;
            ALU_PASS_A: result = a;
            ALU_PASS_B: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/proc_datapath.sv
// Accumulator processor datapath: IR, PC, ACC and output-port registers, operand/address muxes
// and the ALU, obeying the decoder's control word every cycle.
module proc_datapath
    import proc_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  alu_op_t       alu,
    input  logic          muxa,
    input  logic          muxb,
    input  logic          muxc,
    input  logic          rw,
    input  logic          en_ir,
    input  logic          en_da,
    input  logic          en_pc,
    output logic [DW-1:0] ir,
    output logic          carry,
    output logic          zero,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic          out_strobe
);

    logic [DW-1:0] ir_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] out_q;
    logic          strobe_q;

    logic [AW-1:0] operand;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] result;
    logic          port_we;

    assign operand = ir_q[AW-1:0];
    assign port_we = rw & muxc;

    always_comb begin
        alu_a = muxa ? {{(DW-AW){1'b0}}, pc_q} : acc_q;
        if (muxc) begin
            alu_b = in_port;
        end else if (muxb) begin
            alu_b = mem_rdata;
        end else begin
            alu_b = {{(DW-AW){1'b0}}, operand};
        end
    end

    proc_alu #(
        .DW (DW)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            ir_q     <= '0;
            pc_q     <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            if (en_ir) ir_q  <= mem_rdata;
            if (en_da) acc_q <= result;
            if (en_pc) pc_q  <= result[AW-1:0];
            if (port_we) out_q <= result;
            strobe_q <= port_we;
        end
    end

    // Fetch addresses memory by PC; every other access uses the IR operand.
    assign mem_addr   = en_ir ? pc_q : operand;
    assign mem_wdata  = acc_q;
    assign mem_we     = rw & ~muxc;
    assign ir         = ir_q;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;

endmodule
